// File: rtl/updown_step_counter.sv
// rtl/updown_step_counter.sv - loadable up/down counter with programmable step, carry/borrow pulses and zero flag
// Optional feature macro: PRESCALE_EN (enables the PRESCALE-cycle step divider)
module updown_step_counter #(
  parameter int countWidth = 8
`ifdef PRESCALE_EN
  ,
  parameter int PRESCALE   = 4
`endif
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iClear,
  input  logic                  iLoad,
  input  logic [countWidth-1:0] iLoadValue,
  input  logic                  iEnable,
  input  logic                  iUp,
  input  logic [countWidth-1:0] iStep,
  output logic [countWidth-1:0] oCount,
  output logic                  oCarry,
  output logic                  oBorrow,
  output logic                  oZero
);

  logic                  stepFire;
  logic [countWidth:0]   sumWide;
  logic [countWidth:0]   diffWide;
  logic [countWidth-1:0] nextCount;
  logic                  nextCarry;
  logic                  nextBorrow;

`ifdef PRESCALE_EN
  localparam int divWidth = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [divWidth-1:0] divTerminal = divWidth'(PRESCALE - 1);

  logic [divWidth-1:0] divCount;

  // Divider advances only on enabled cycles with no clear/load, wrapping at the terminal value
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      divCount <= '0;
    end else if (iClear || iLoad) begin
      divCount <= '0;
    end else if (iEnable) begin
      if (divCount == divTerminal) begin
        divCount <= '0;
      end else begin
        divCount <= divCount + 1'b1;
      end
    end
  end

  assign stepFire = iEnable && !iClear && !iLoad && (divCount == divTerminal);
`else
  assign stepFire = iEnable && !iClear && !iLoad;
`endif

  // The extra top bit of each wide result is the wrap indicator
  assign sumWide  = {1'b0, oCount} + {1'b0, iStep};
  assign diffWide = {1'b0, oCount} - {1'b0, iStep};

  // Next-state selection with clear > load > step priority; pulses default to 0
  always_comb begin
    nextCount  = oCount;
    nextCarry  = 1'b0;
    nextBorrow = 1'b0;
    if (iClear) begin
      nextCount = '0;
    end else if (iLoad) begin
      nextCount = iLoadValue;
    end else if (stepFire) begin
      if (iUp) begin
        nextCount = sumWide[countWidth-1:0];
        nextCarry = sumWide[countWidth];
      end else begin
        nextCount  = diffWide[countWidth-1:0];
        nextBorrow = diffWide[countWidth];
      end
    end
  end

  // Count, pulses and zero flag all register together so they stay aligned
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      oCount  <= '0;
      oCarry  <= 1'b0;
      oBorrow <= 1'b0;
      oZero   <= 1'b1;
    end else begin
      oCount  <= nextCount;
      oCarry  <= nextCarry;
      oBorrow <= nextBorrow;
      oZero   <= (nextCount == '0);
    end
  end

endmodule
